bitstream_decoder: RTL and testbench

//  Stochastic-to-binary converter downstream of the bitstream network output layer.
//  - Counts ones on each output bitstream over one STREAM_LEN-cycle evaluation window.
//  - Presents the counts as binary results with a valid/ready handshake.

---
 rtl/bitstream_pkg.sv | 13 +
 rtl/bitstream_decoder_ones_counter.sv | 19 +
 rtl/bitstream_decoder.sv | 80 ++++++++
 tb/tb_bitstream_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bitstream_pkg.sv
// bitstream_pkg: shared types and sizing for the bitstream decoder (lane width depends on BITSTREAM_BIPOLAR_EN)
package bitstream_pkg;
  localparam int STREAM_LEN_DEFAULT = 128;
`ifdef BITSTREAM_BIPOLAR_EN
  localparam int LANE_EXTRA = 1;
`else
  localparam int LANE_EXTRA = 0;
`endif
  typedef enum logic [1:0] {DEC_IDLE, DEC_ACCUM, DEC_HOLD} dec_state_t;
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction
endpackage

// File: rtl/bitstream_decoder_ones_counter.sv
// ones_counter: per-channel population counter with synchronous clear and enable
module ones_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  // clear wins over accumulate so a new window always starts from zero
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else if (clear) count_q <= '0;
    else if (en) count_q <= count_q + W'(bit_in);
  assign count = count_q;
endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts ones per channel over a window and presents results via valid/ready (signed lanes with BITSTREAM_BIPOLAR_EN)
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter  int CHANNELS   = 1,
  parameter  int STREAM_LEN = STREAM_LEN_DEFAULT,
  localparam int CNT_W      = cnt_width(STREAM_LEN),
  localparam int LW         = CNT_W + LANE_EXTRA
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CHANNELS-1:0]    stream_in,
  input  logic                   res_ready,
  output logic                   res_valid,
  output logic [CHANNELS*LW-1:0] res_data,
  output logic                   busy
);
  dec_state_t            state_q;
  logic [CNT_W-1:0]      samp_q;
  logic                  res_valid_q, busy_q;
  logic [CHANNELS*LW-1:0] res_data_q, fin;
  logic                  clear, en, last;
  assign en    = state_q == DEC_ACCUM;
  assign clear = start && (state_q == DEC_IDLE || (state_q == DEC_HOLD && res_ready));
  assign last  = en && samp_q == CNT_W'(STREAM_LEN - 1);
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [CNT_W-1:0] cnt, sum;
      ones_counter #(.W(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .clear(clear), .en(en), .bit_in(stream_in[c]), .count(cnt)
      );
      assign sum = cnt + CNT_W'(stream_in[c]);
`ifdef BITSTREAM_BIPOLAR_EN
      assign fin[c*LW +: LW] = {sum, 1'b0} - LW'(STREAM_LEN);
`else
      assign fin[c*LW +: LW] = sum;
`endif
    end
  endgenerate
  // window FSM: final count includes the bit sampled on the last cycle; HOLD can restart directly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= DEC_IDLE;
      samp_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        DEC_IDLE:
          if (start) begin
            state_q <= DEC_ACCUM;
            samp_q  <= '0;
            busy_q  <= 1'b1;
          end
        DEC_ACCUM: begin
          samp_q <= samp_q + CNT_W'(1);
          if (last) begin
            state_q     <= DEC_HOLD;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b1;
            res_data_q  <= fin;
          end
        end
        DEC_HOLD:
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= start ? DEC_ACCUM : DEC_IDLE;
            busy_q      <= start;
            samp_q      <= '0;
          end
        default: state_q <= DEC_IDLE;
      endcase
    end
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_bitstream_decoder.sv
// tb_bitstream_decoder: directed self-checking bench for bitstream_decoder, two channels, 128-cycle window
module tb_bitstream_decoder;
  import bitstream_pkg::*;
  localparam int CH = 2;
  localparam int SL = 128;
  localparam int LW = cnt_width(SL) + LANE_EXTRA;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, res_ready = 1'b0;
  logic [CH-1:0] stream_in = '0;
  logic res_valid, busy;
  logic [CH*LW-1:0] res_data;
  int checks = 0, failures = 0;
  bitstream_decoder #(.CHANNELS(CH), .STREAM_LEN(SL)) dut (
    .clk(clk), .rst(rst), .start(start), .stream_in(stream_in),
    .res_ready(res_ready), .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [LW-1:0] ex(input int n);
`ifdef BITSTREAM_BIPOLAR_EN
    return LW'(2 * n - SL);
`else
    return LW'(n);
`endif
  endfunction
  function automatic logic [31:0] pair(input int n1, input int n0);
    return 32'({ex(n1), ex(n0)});
  endfunction
  function automatic logic bits(input int m, input int i, input int k);
    case (m)
      1: return 1'b1;
      2: return i % 2 == 0;
      3: return i < k;
      4: return i % 2 == 1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic accum(input string tag, input int m0, input int m1, input int k0, input int k1, input int sp);
    for (int i = 0; i < SL; i++) begin
      stream_in = {bits(m1, i, k1), bits(m0, i, k0)};
      start = i == sp;
      if (i == SL - 1) begin
        chk({tag, "_valid_early"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy_accum"}, 32'(busy), 32'd1);
      end
      tick();
    end
    start = 1'b0;
    stream_in = '0;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_busy_hold"}, 32'(busy), 32'd0);
  endtask
  task automatic take(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    tick();
    stream_in = 2'b11;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    // ch0 all ones, ch1 all zeros
    go();
    chk("t2_busy_start", 32'(busy), 32'd1);
    accum("t2", 1, 0, 0, 0, -1);
    chk("t2_data", 32'(res_data), pair(0, 128));
    take("t2");
    chk("t2_busy_idle", 32'(busy), 32'd0);
    // reset in the middle of a window
    go();
    for (int i = 0; i < 60; i++) begin
      stream_in = 2'b11;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t1_async_valid", 32'(res_valid), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    tick();
    chk("t1_valid", 32'(res_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    stream_in = '0;
    tick();
    go();
    accum("t1b", 0, 1, 0, 0, -1);
    chk("t1b_data", 32'(res_data), pair(128, 0));
    take("t1b");
    // alternating streams
    go();
    accum("t3", 2, 4, 0, 0, -1);
    chk("t3_data", 32'(res_data), pair(64, 64));
    // stall for 20 cycles with toggling input
    for (int i = 0; i < 20; i++) begin
      stream_in = i[0] ? 2'b01 : 2'b10;
      start = i == 5;
      tick();
      chk("t4_hold_valid", 32'(res_valid), 32'd1);
      chk("t4_hold_data", 32'(res_data), pair(64, 64));
    end
    start = 1'b0;
    stream_in = '0;
    take("t4");
    chk("t4_data_kept", 32'(res_data), pair(64, 64));
    chk("t4_busy", 32'(busy), 32'd0);
    // back-to-back windows
    go();
    accum("t5a", 3, 0, 32, 0, -1);
    chk("t5a_data", 32'(res_data), pair(0, 32));
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    chk("t5_valid_drop", 32'(res_valid), 32'd0);
    chk("t5_busy_restart", 32'(busy), 32'd1);
    accum("t5b", 3, 1, 96, 0, -1);
    chk("t5b_data", 32'(res_data), pair(128, 96));
    take("t5b");
    // start during accumulation is ignored
    go();
    accum("t6", 1, 2, 0, 0, 50);
    chk("t6_data", 32'(res_data), pair(64, 128));
    take("t6");
    tick();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
